decodificador_param: RTL and testbench
======================================

DECODIFICADOR_PARAM -- requirements
Module: decodificador_param

Interface
REQ-001 Parameter ANCHO, default 3: select width; output width is 2**ANCHO; legal range 1..6.
REQ-002 Parameter INVERTIR, default 1: 1 = legacy mapping, the hot bit is Salida[2**ANCHO-1-Indice]; 0 = direct mapping, the hot bit is Salida[Indice].
REQ-003 Reloj  input  1  single clock; all state updates on the rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 Habilitar  input  1  clock enable; when 0, all registers hold their value (Reset still acts).
REQ-006 Cargar  input  1  single-cycle load request; samples Entrada and Barrido.
REQ-007 Barrido  input  1  mode select at load: 0 = static decode, 1 = sweep.
REQ-008 Parar  input  1  return to idle.
REQ-009 Entrada  input  ANCHO  select value, or start index in sweep mode.
REQ-010 Salida  output  2**ANCHO  registered one-hot decode of Indice; all zeros when idle.
REQ-011 Indice  output  ANCHO  current registered index.
REQ-012 Valido  output  1  high when Salida carries a decode (state FIJO or BARRE).
REQ-013 Vuelta  output  1  one-cycle pulse when the sweep wraps from 2**ANCHO-1 to 0.

Function
REQ-014 The FSM SHALL have three states: REPOSO, FIJO, BARRE; encoding is free.
REQ-015 All outputs SHALL be registered; there is no combinational path from any input to any output.
REQ-016 Qualifier: the remaining Function rules (REQ-017..REQ-024) SHALL apply only in cycles where Habilitar=1.
REQ-017 In any state, Parar=1 -> next state REPOSO, with Salida=0, Valido=0 and Indice held; Parar has priority over Cargar.
REQ-018 In any state, Cargar=1 with Parar=0 -> Indice<=Entrada; next state FIJO if Barrido=0, otherwise BARRE; Salida and Valido update on the same edge, giving 1-cycle latency from Cargar to the decoded output.
REQ-019 FIJO with no request -> Indice and Salida hold; Valido=1.
REQ-020 BARRE with no request -> Indice<=Indice+1 modulo 2**ANCHO each cycle; Salida tracks the new Indice on the same edge.
REQ-021 On the BARRE edge where Indice goes from 2**ANCHO-1 to 0, Vuelta SHALL be 1 for exactly that following cycle; otherwise Vuelta=0.
REQ-022 A reload (Cargar) during BARRE restarts from Entrada and SHALL NOT pulse Vuelta, even when Entrada=0.
REQ-023 Salida SHALL be exactly one-hot whenever Valido=1, and all zeros whenever Valido=0.
REQ-024 Mode bit Barrido SHALL be sampled only with Cargar; changes at other times have no effect.
REQ-025 Habilitar=0 freezes state, Indice and Salida; Vuelta SHALL be 0 during frozen cycles and is not re-pulsed on resume.

Reset
REQ-026 Reset=1 at a rising edge -> state REPOSO, Indice=0, Salida=0, Valido=0, Vuelta=0, regardless of Habilitar, Cargar or Parar.
REQ-027 Reset mid-sweep SHALL abort the sweep with no Vuelta pulse; the first Cargar after reset behaves as from power-up.

Verification
REQ-028 ANCHO=3, INVERTIR=1: Cargar with Entrada=3'b111, Barrido=0 -> next cycle Salida=8'h01, Valido=1; Entrada=3'b000 -> Salida=8'h80.
REQ-029 ANCHO=3, INVERTIR=0: static load of 5 -> Salida=8'h20, held for 10 idle cycles; Parar -> Salida=8'h00, Valido=0, Indice=5.
REQ-030 ANCHO=3, INVERTIR=0, sweep from 6 -> Indice sequence 6,7,0,1; Vuelta=1 only in the cycle Indice=0.
REQ-031 Sweep with Habilitar low for 3 cycles at Indice=7 -> Indice stays 7; resume -> Indice=0 and one Vuelta pulse.
REQ-032 Cargar and Parar asserted together in BARRE -> REPOSO; assert Reset mid-sweep -> all outputs 0 on the next cycle, no Vuelta.
REQ-033 Run REQ-028..REQ-032 for ANCHO=1 and ANCHO=6, checking one-hot-or-zero on Salida every cycle.

Source files
------------

// File: rtl/decodificador_param_if.sv
// Handshake/bus bundle for decodificador_param: control requests in, registered decode out.
// Latency: none of its own; it is only a set of wires.
// Backpressure: none; the bundle carries no ready path.
// Ports: habilitar/cargar/barrido/parar/entrada come from the master side.
//        salida/indice/valido/vuelta come from the slave (decoder) side.
interface decodificador_param_if #(
  parameter int ANCHO = 3
);
  logic                    habilitar;
  logic                    cargar;
  logic                    barrido;
  logic                    parar;
  logic [ANCHO-1:0]        entrada;
  logic [(1<<ANCHO)-1:0]   salida;
  logic [ANCHO-1:0]        indice;
  logic                    valido;
  logic                    vuelta;

  modport master (
    output habilitar, cargar, barrido, parar, entrada,
    input  salida, indice, valido, vuelta
  );

  modport slave (
    input  habilitar, cargar, barrido, parar, entrada,
    output salida, indice, valido, vuelta
  );
endinterface

// File: rtl/decodificador_param.sv
// Registered one-hot decoder with a static mode and a free-running sweep mode.
// Latency: 1 cycle from cargar to the decoded salida; every output is a flop.
// Backpressure: none; habilitar=0 freezes all state (vuelta reads 0 while frozen).
// Ports: reloj (rising-edge clock), reset (synchronous, active high),
//        bus.slave: habilitar, cargar, barrido, parar, entrada in;
//                   salida (2**ANCHO one-hot), indice, valido, vuelta out.
module decodificador_param #(
  parameter int ANCHO    = 3,
  parameter int INVERTIR = 1
) (
  input  logic                 reloj,
  input  logic                 reset,
  decodificador_param_if.slave bus
);

  localparam int N = 1 << ANCHO;

  typedef enum logic [1:0] {
    REPOSO = 2'd0,
    FIJO   = 2'd1,
    BARRE  = 2'd2
  } estado_t;

  estado_t          estado;
  logic [ANCHO-1:0] indice;
  logic [ANCHO-1:0] siguiente;
  logic [N-1:0]     salida;
  logic             valido;
  logic             vuelta;

  assign siguiente = indice + 1'b1;

  // Legacy mapping puts the hot bit at N-1-i, which for an ANCHO-bit
  // index is simply the bitwise complement of i.
  function automatic logic [N-1:0] decodifica(input logic [ANCHO-1:0] i);
    logic [N-1:0]     r;
    logic [ANCHO-1:0] p;
    p    = (INVERTIR != 0) ? ~i : i;
    r    = '0;
    r[p] = 1'b1;
    return r;
  endfunction

  always_ff @(posedge reloj) begin
    if (reset) begin
      estado <= REPOSO;
      indice <= '0;
      salida <= '0;
      valido <= 1'b0;
      vuelta <= 1'b0;
    end else if (!bus.habilitar) begin
      // Frozen: everything holds except the wrap pulse, which must not
      // stretch across stalled cycles.
      vuelta <= 1'b0;
    end else begin
      vuelta <= 1'b0;
      if (bus.parar) begin
        // Indice is deliberately kept so the last position stays visible.
        estado <= REPOSO;
        salida <= '0;
        valido <= 1'b0;
      end else if (bus.cargar) begin
        // A reload never counts as a wrap, even when entrada is 0.
        indice <= bus.entrada;
        estado <= bus.barrido ? BARRE : FIJO;
        salida <= decodifica(bus.entrada);
        valido <= 1'b1;
      end else if (estado == BARRE) begin
        indice <= siguiente;
        salida <= decodifica(siguiente);
        vuelta <= (indice == {ANCHO{1'b1}});
      end
    end
  end

  assign bus.salida = salida;
  assign bus.indice = indice;
  assign bus.valido = valido;
  assign bus.vuelta = vuelta;

endmodule

// File: tb/tb_decodificador_param.sv
// Self-checking bench: four decoder instances (different ANCHO/INVERTIR)
// share one stimulus stream and are compared every cycle to a reference model.
module tb_decodificador_param;

  logic       reloj = 1'b0;
  logic       reset;
  logic       hab, cargar, barrido, parar;
  logic [5:0] ent;

  int tests = 0;
  int errs  = 0;

  always #5 reloj = ~reloj;

  decodificador_param_if #(.ANCHO(3)) if0 ();
  decodificador_param_if #(.ANCHO(3)) if1 ();
  decodificador_param_if #(.ANCHO(1)) if2 ();
  decodificador_param_if #(.ANCHO(6)) if3 ();

  decodificador_param #(.ANCHO(3), .INVERTIR(1)) dut0 (.reloj(reloj), .reset(reset), .bus(if0.slave));
  decodificador_param #(.ANCHO(3), .INVERTIR(0)) dut1 (.reloj(reloj), .reset(reset), .bus(if1.slave));
  decodificador_param #(.ANCHO(1), .INVERTIR(1)) dut2 (.reloj(reloj), .reset(reset), .bus(if2.slave));
  decodificador_param #(.ANCHO(6), .INVERTIR(0)) dut3 (.reloj(reloj), .reset(reset), .bus(if3.slave));

  assign if0.habilitar = hab;  assign if1.habilitar = hab;
  assign if2.habilitar = hab;  assign if3.habilitar = hab;
  assign if0.cargar    = cargar; assign if1.cargar = cargar;
  assign if2.cargar    = cargar; assign if3.cargar = cargar;
  assign if0.barrido   = barrido; assign if1.barrido = barrido;
  assign if2.barrido   = barrido; assign if3.barrido = barrido;
  assign if0.parar     = parar; assign if1.parar = parar;
  assign if2.parar     = parar; assign if3.parar = parar;
  assign if0.entrada   = ent[2:0];
  assign if1.entrada   = ent[2:0];
  assign if2.entrada   = ent[0:0];
  assign if3.entrada   = ent[5:0];

  logic [63:0] sal_o [4];
  logic [5:0]  idx_o [4];
  logic        val_o [4];
  logic        vu_o  [4];

  assign sal_o[0] = 64'(if0.salida); assign idx_o[0] = 6'(if0.indice);
  assign sal_o[1] = 64'(if1.salida); assign idx_o[1] = 6'(if1.indice);
  assign sal_o[2] = 64'(if2.salida); assign idx_o[2] = 6'(if2.indice);
  assign sal_o[3] = 64'(if3.salida); assign idx_o[3] = 6'(if3.indice);
  assign val_o[0] = if0.valido; assign vu_o[0] = if0.vuelta;
  assign val_o[1] = if1.valido; assign vu_o[1] = if1.vuelta;
  assign val_o[2] = if2.valido; assign vu_o[2] = if2.vuelta;
  assign val_o[3] = if3.valido; assign vu_o[3] = if3.vuelta;

  // Reference model: mode 0 = idle, 1 = static, 2 = sweeping.
  int anc [4] = '{3, 3, 1, 6};
  int inv [4] = '{1, 0, 1, 0};
  int m_st  [4];
  int m_idx [4];
  int m_vu  [4];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] exp_sal(input int k);
    int n, pos;
    n = 1 << anc[k];
    if (m_st[k] == 0) return 64'd0;
    pos = (inv[k] != 0) ? (n - 1 - m_idx[k]) : m_idx[k];
    return 64'd1 << pos;
  endfunction

  task automatic model_step();
    for (int k = 0; k < 4; k++) begin
      int n;
      n = 1 << anc[k];
      if (reset) begin
        m_st[k] = 0; m_idx[k] = 0; m_vu[k] = 0;
      end else if (!hab) begin
        m_vu[k] = 0;
      end else if (parar) begin
        m_st[k] = 0; m_vu[k] = 0;
      end else if (cargar) begin
        m_idx[k] = int'(ent) % n;
        m_st[k]  = barrido ? 2 : 1;
        m_vu[k]  = 0;
      end else if (m_st[k] == 2) begin
        m_vu[k]  = (m_idx[k] == n - 1) ? 1 : 0;
        m_idx[k] = (m_idx[k] + 1) % n;
      end else begin
        m_vu[k] = 0;
      end
    end
  endtask

  task automatic tick();
    @(posedge reloj);
    model_step();
    #1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("salida%0d", k), sal_o[k], exp_sal(k));
      chk($sformatf("indice%0d", k), 64'(idx_o[k]), 64'(m_idx[k]));
      chk($sformatf("valido%0d", k), 64'(val_o[k]), 64'(m_st[k] != 0));
      chk($sformatf("vuelta%0d", k), 64'(vu_o[k]), 64'(m_vu[k]));
      chk($sformatf("onehot%0d", k), 64'($countones(sal_o[k])), 64'(val_o[k] ? 1 : 0));
    end
  endtask

  initial begin
    reset = 1'b1; hab = 1'b1; cargar = 1'b0; barrido = 1'b0; parar = 1'b0; ent = '0;
    for (int k = 0; k < 4; k++) begin m_st[k] = 0; m_idx[k] = 0; m_vu[k] = 0; end
    tick(); tick();
    chk("rst_sal", sal_o[1], 64'h0);
    chk("rst_val", 64'(val_o[0]), 64'h0);
    reset = 1'b0;
    tick();

    // Legacy mapping: index 7 lands on bit 0, index 0 on bit 7.
    ent = 6'd7; cargar = 1'b1; tick(); cargar = 1'b0;
    chk("leg7", sal_o[0], 64'h01);
    chk("leg7_val", 64'(val_o[0]), 64'h1);
    ent = 6'd0; cargar = 1'b1; tick(); cargar = 1'b0;
    chk("leg0", sal_o[0], 64'h80);

    // Static load of 5 held through idle cycles, then stopped.
    ent = 6'd5; cargar = 1'b1; tick(); cargar = 1'b0;
    chk("dir5", sal_o[1], 64'h20);
    barrido = 1'b1;  // mode changes without cargar must be ignored
    repeat (10) tick();
    barrido = 1'b0;
    chk("dir5_hold", sal_o[1], 64'h20);
    chk("dir5_idx", 64'(idx_o[1]), 64'd5);
    parar = 1'b1; tick(); parar = 1'b0;
    chk("parar_sal", sal_o[1], 64'h0);
    chk("parar_val", 64'(val_o[1]), 64'h0);
    chk("parar_idx", 64'(idx_o[1]), 64'd5);

    // Sweep from 6 with a 3-cycle freeze at 7, then wrap.
    ent = 6'd6; barrido = 1'b1; cargar = 1'b1; tick(); cargar = 1'b0; barrido = 1'b0;
    chk("sw6", 64'(idx_o[1]), 64'd6);
    tick();
    chk("sw7", 64'(idx_o[1]), 64'd7);
    hab = 1'b0;
    repeat (3) begin
      tick();
      chk("frz_idx", 64'(idx_o[1]), 64'd7);
      chk("frz_vu", 64'(vu_o[1]), 64'd0);
    end
    hab = 1'b1;
    tick();
    chk("wrap_idx", 64'(idx_o[1]), 64'd0);
    chk("wrap_vu", 64'(vu_o[1]), 64'd1);
    tick();
    chk("sw1", 64'(idx_o[1]), 64'd1);
    chk("sw1_vu", 64'(vu_o[1]), 64'd0);

    // Reload to 0 at index 7 must not pulse vuelta.
    ent = 6'd6; barrido = 1'b1; cargar = 1'b1; tick();
    cargar = 1'b0; tick();
    ent = 6'd0; cargar = 1'b1; tick(); cargar = 1'b0; barrido = 1'b0;
    chk("reload_idx", 64'(idx_o[1]), 64'd0);
    chk("reload_vu", 64'(vu_o[1]), 64'd0);

    // Cargar and parar together: parar wins.
    cargar = 1'b1; parar = 1'b1; ent = 6'd3; tick(); cargar = 1'b0; parar = 1'b0;
    chk("prio_val", 64'(val_o[1]), 64'd0);

    // Reset mid-sweep at index 7: everything zero, no wrap pulse.
    ent = 6'd7; barrido = 1'b1; cargar = 1'b1; tick(); cargar = 1'b0; barrido = 1'b0;
    reset = 1'b1; hab = 1'b0; tick(); reset = 1'b0; hab = 1'b1;
    chk("rsw_sal", sal_o[3], 64'h0);
    chk("rsw_idx", 64'(idx_o[1]), 64'd0);
    chk("rsw_vu", 64'(vu_o[1]), 64'd0);
    tick();

    // Randomized traffic against the model.
    for (int i = 0; i < 800; i++) begin
      reset   = ($urandom_range(0, 59) == 0);
      hab     = ($urandom_range(0, 7) != 0);
      cargar  = ($urandom_range(0, 4) == 0);
      parar   = ($urandom_range(0, 11) == 0);
      barrido = $urandom_range(0, 1) != 0;
      ent     = 6'($urandom);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end

endmodule
